// File: rtl/multi_stage_sync_filter_if.sv
// Level-signal bundle for multi_stage_sync_filter: raw async inputs in, filtered levels and edge pulses out.
interface multi_stage_sync_filter_if #(
  parameter int N = 16
);
  logic [N-1:0] dataIn;
  logic [N-1:0] dataOut;
  logic [N-1:0] riseOut;
  logic [N-1:0] fallOut;

  modport master (output dataIn, input dataOut, input riseOut, input fallOut);
  modport slave  (input dataIn, output dataOut, output riseOut, output fallOut);
endinterface

// File: rtl/multi_stage_sync_filter.sv
// Per-bit STAGES-deep synchronizer followed by a FILTER_CYCLES persistence filter.
// Define SYNC_EDGE_DETECT_EN to get registered riseOut/fallOut pulses; otherwise they are tied low.
module multi_stage_sync_filter #(
  parameter int           N             = 16,
  parameter int           STAGES        = 2,
  parameter int           FILTER_CYCLES = 4,
  parameter logic [N-1:0] RESET_VAL     = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  multi_stage_sync_filter_if.slave   bus
);
  localparam int            CW       = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  if (N < 1) begin : g_bad_n
    $error("multi_stage_sync_filter: N must be >= 1");
  end
  if (STAGES < 2) begin : g_bad_stages
    $error("multi_stage_sync_filter: STAGES must be >= 2");
  end
  if (FILTER_CYCLES < 1) begin : g_bad_filter
    $error("multi_stage_sync_filter: FILTER_CYCLES must be >= 1");
  end

  logic [N-1:0]  sync_q [STAGES];
  logic [N-1:0]  syncd;
  logic [N-1:0]  data_q;
  logic [N-1:0]  take;
  logic [CW-1:0] cnt_q [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) sync_q[k] <= RESET_VAL;
    end else begin
      sync_q[0] <= bus.dataIn;
      for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign syncd = sync_q[STAGES-1];

  // A bit flips only on the cycle its mismatch has already persisted FILTER_CYCLES-1 cycles.
  always_comb begin
    take = '0;
    for (int i = 0; i < N; i++) begin
      take[i] = (syncd[i] != data_q[i]) && (cnt_q[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RESET_VAL;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      data_q <= (data_q & ~take) | (syncd & take);
      for (int i = 0; i < N; i++) begin
        if ((syncd[i] == data_q[i]) || take[i]) cnt_q[i] <= '0;
        else                                     cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  assign bus.dataOut = data_q;

`ifdef SYNC_EDGE_DETECT_EN
  logic [N-1:0] rise_q;
  logic [N-1:0] fall_q;

  // Pulses line up with the first cycle of the new dataOut level; reset never produces one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= take & syncd;
      fall_q <= take & ~syncd;
    end
  end

  assign bus.riseOut = rise_q;
  assign bus.fallOut = fall_q;
`else
  assign bus.riseOut = '0;
  assign bus.fallOut = '0;
`endif

endmodule

// File: tb/tb_multi_stage_sync_filter.sv
// Directed plus randomized bench for multi_stage_sync_filter against a run-length reference model.
module tb_multi_stage_sync_filter;
  localparam int           N         = 16;
  localparam int           STAGES    = 2;
  localparam int           FC        = 4;
  localparam logic [N-1:0] RESET_VAL = '0;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  multi_stage_sync_filter_if #(.N(N)) bus ();

  multi_stage_sync_filter #(
    .N(N), .STAGES(STAGES), .FILTER_CYCLES(FC), .RESET_VAL(RESET_VAL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: syncd is dataIn as sampled STAGES edges earlier; a level is adopted once it has disagreed FC edges in a row.
  logic [N-1:0] samples [$];
  logic [N-1:0] m_out;
  logic [N-1:0] m_rise;
  logic [N-1:0] m_fall;
  int           run [N];

  task automatic model_reset();
    m_out  = RESET_VAL;
    m_rise = '0;
    m_fall = '0;
    samples.delete();
    for (int i = 0; i < N; i++) run[i] = 0;
  endtask

  task automatic model_edge();
    logic [N-1:0] syncd;
    if (rst) begin
      model_reset();
      return;
    end
    syncd  = (samples.size() >= STAGES) ? samples[samples.size()-STAGES] : RESET_VAL;
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < N; i++) begin
      if (syncd[i] != m_out[i]) begin
        run[i]++;
        if (run[i] == FC) begin
          m_out[i]  = syncd[i];
          m_rise[i] = syncd[i];
          m_fall[i] = ~syncd[i];
          run[i]    = 0;
        end
      end else begin
        run[i] = 0;
      end
    end
    samples.push_back(bus.dataIn);
    if (samples.size() > STAGES) void'(samples.pop_front());
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [N-1:0] exp_rise;
    logic [N-1:0] exp_fall;
    @(posedge clk);
    model_edge();
    @(negedge clk);
`ifdef SYNC_EDGE_DETECT_EN
    exp_rise = m_rise;
    exp_fall = m_fall;
`else
    exp_rise = '0;
    exp_fall = '0;
`endif
    chk("dataOut", bus.dataOut, m_out);
    chk("riseOut", bus.riseOut, exp_rise);
    chk("fallOut", bus.fallOut, exp_fall);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    logic [N-1:0] d;
    clk   = 1'b0;
    rst   = 1'b1;
    total = 0;
    bad   = 0;
    bus.dataIn = 16'hFFFF;
    model_reset();

    // T1: reset holds outputs low with all inputs high; release takes 6 edges
    ticks(3);
    chk("t1_reset_out", bus.dataOut, 16'h0000);
    rst = 1'b0;
    ticks(5);
    chk("t1_edge5_out", bus.dataOut, 16'h0000);
    tick();
    chk("t1_edge6_out", bus.dataOut, 16'hFFFF);
    ticks(2);

    // T2: single-bit latency
    bus.dataIn = 16'h0000;
    ticks(8);
    bus.dataIn = 16'h0008;
    ticks(5);
    chk("t2_edge5_out", bus.dataOut, 16'h0000);
    tick();
    chk("t2_edge6_out", bus.dataOut, 16'h0008);
    ticks(3);

    // T3: 3-cycle glitch is rejected, 4-cycle level is accepted
    bus.dataIn = 16'h0000;
    ticks(8);
    bus.dataIn = 16'h0001;
    ticks(3);
    bus.dataIn = 16'h0000;
    ticks(8);
    chk("t3_glitch3_out", bus.dataOut, 16'h0000);
    bus.dataIn = 16'h0001;
    ticks(4);
    bus.dataIn = 16'h0000;
    ticks(2);
    chk("t3_pulse4_out", bus.dataOut, 16'h0001);
    ticks(8);

    // T4: bounce on bit 7, then settle high
    for (int k = 0; k < 10; k++) begin
      bus.dataIn = (k % 2 == 0) ? 16'h0080 : 16'h0000;
      ticks(2);
    end
    bus.dataIn = 16'h0080;
    ticks(5);
    chk("t4_edge5_out", bus.dataOut, 16'h0000);
    tick();
    chk("t4_edge6_out", bus.dataOut, 16'h0080);
    ticks(3);

    // T5: reset in the middle of a pending rise on bit 5
    bus.dataIn = 16'h0000;
    ticks(8);
    bus.dataIn = 16'h0020;
    ticks(4);
    rst = 1'b1;
    ticks(2);
    chk("t5_reset_out", bus.dataOut, 16'h0000);
    rst = 1'b0;
    ticks(5);
    chk("t5_edge5_out", bus.dataOut, 16'h0000);
    tick();
    chk("t5_edge6_out", bus.dataOut, 16'h0020);
    ticks(3);

    // Random phase: sparse per-bit toggles with occasional resets
    d = bus.dataIn;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) d = d ^ ($urandom & $urandom);
      else                           d = d ^ ($urandom & $urandom & $urandom);
      bus.dataIn = d;
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        ticks($urandom_range(1, 2));
        rst = 1'b0;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
